vec_wb_collector: RTL

VEC_WB_COLLECTOR -- requirements
Module: vec_wb_collector

---
 rtl/vec_pkg.sv | 29 ++
 rtl/vec_wb_lane_merge.sv | 33 +++
 rtl/vec_wb_collector.sv | 124 ++++++++++++
 3 files changed

// File: rtl/vec_pkg.sv
// Shared vector-unit types: writeback FSM states, operand-type codes and the
// helper that turns an element width into a per-lane chunk width.
package vec_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_WRITE   = 2'd2
    } wb_state_e;

    typedef enum logic [1:0] {
        OP_VV = 2'd0,
        OP_VX = 2'd1,
        OP_VI = 2'd2
    } op_type_e;

    localparam int NUM_LANES   = 4;
    localparam int LANE_DATA_W = 64;
    localparam int REGI_W      = 10;

    // Zero marks a reserved vsew; every lane write under it is dropped.
    function automatic int chunk_width(input logic [2:0] vsew, input int lane_width);
        int ew;
        if (vsew > 3'd3) return 0;
        ew = 8 << vsew;
        return (ew < (1 << lane_width)) ? ew : (1 << lane_width);
    endfunction

endpackage

// File: rtl/vec_wb_lane_merge.sv
// Merges one lane's W-bit chunk into the destination buffer at a bit offset;
// out-of-range or zero-width chunks leave the buffer alone and raise drop.
import vec_pkg::*;

module vec_wb_lane_merge #(
    parameter int VLEN       = 128,
    parameter int LANE_WIDTH = 4
) (
    input  logic [VLEN-1:0]        buf_in,
    input  logic [LANE_DATA_W-1:0] data,
    input  logic [REGI_W-1:0]      offset,
    input  logic [LANE_WIDTH:0]    w,
    input  logic                   enable,
    output logic [VLEN-1:0]        buf_out,
    output logic                   drop
);

    logic                   in_range;
    logic [LANE_DATA_W-1:0] low_mask;
    logic [VLEN-1:0]        chunk_mask;
    logic [VLEN-1:0]        chunk_data;

    always_comb begin
        in_range   = (w != '0) && ((int'(offset) + int'(w)) <= VLEN);
        low_mask   = (int'(w) >= LANE_DATA_W) ? '1
                   : ((LANE_DATA_W'(1) << w) - LANE_DATA_W'(1));
        chunk_mask = VLEN'(low_mask) << offset;
        chunk_data = VLEN'(data & low_mask) << offset;
        drop       = enable && !in_range;
        buf_out    = (enable && in_range) ? ((buf_in & ~chunk_mask) | chunk_data) : buf_in;
    end

endmodule

// File: rtl/vec_wb_collector.sv
// Collects per-lane result chunks into a VLEN-bit destination buffer over
// several beats, then issues a single register-file writeback.
import vec_pkg::*;

module vec_wb_collector #(
    parameter int VLEN       = 128,
    parameter int LANE_WIDTH = 4
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic [4:0]       vd_addr,
    input  logic [VLEN-1:0]  old_vd,
    input  logic [1:0]       nb_lanes,
    input  logic [2:0]       vsew,
    input  logic             run0,
    input  logic             run1,
    input  logic             run2,
    input  logic             run3,
    input  logic [63:0]      vd0,
    input  logic [63:0]      vd1,
    input  logic [63:0]      vd2,
    input  logic [63:0]      vd3,
    input  logic [9:0]       regi0,
    input  logic [9:0]       regi1,
    input  logic [9:0]       regi2,
    input  logic [9:0]       regi3,
    input  logic             beat_last,
    output logic             busy,
    output logic             wb_valid,
    input  logic             wb_ready,
    output logic [4:0]       wb_vreg,
    output logic [VLEN-1:0]  wb_data,
    output logic             err,
    output wb_state_e        state_dbg
);

    // Writeback handshake: a transfer happens on a clk edge where wb_valid and
    // wb_ready are both high. Once wb_valid rises, wb_data and wb_vreg hold and
    // wb_valid stays high until that transfer; wb_ready may toggle freely.

    wb_state_e              state;
    logic [VLEN-1:0]        vbuf;
    logic [NUM_LANES-1:0]   run_v;
    logic [NUM_LANES-1:0]   lane_on;
    logic [NUM_LANES-1:0]   lane_en;
    logic [NUM_LANES-1:0]   lane_drop;
    logic [LANE_DATA_W-1:0] vd_a   [NUM_LANES];
    logic [REGI_W-1:0]      regi_a [NUM_LANES];
    logic [VLEN-1:0]        chain  [NUM_LANES+1];
    logic [LANE_WIDTH:0]    chunk_w;
    logic                   stray;
    logic                   accept_start;

    assign run_v     = {run3, run2, run1, run0};
    assign vd_a[0]   = vd0;
    assign vd_a[1]   = vd1;
    assign vd_a[2]   = vd2;
    assign vd_a[3]   = vd3;
    assign regi_a[0] = regi0;
    assign regi_a[1] = regi1;
    assign regi_a[2] = regi2;
    assign regi_a[3] = regi3;

    always_comb begin
        chunk_w = (LANE_WIDTH+1)'(chunk_width(vsew, LANE_WIDTH));
        lane_on = '0;
        for (int i = 0; i < NUM_LANES; i++) lane_on[i] = (i < (1 << nb_lanes));
        lane_en = run_v & lane_on & {NUM_LANES{state == ST_COLLECT}};
        // Lane activity or beat_last while not collecting is a protocol slip.
        stray   = (state != ST_COLLECT) && ((|run_v) || beat_last);
        accept_start = start && ((state == ST_IDLE) || ((state == ST_WRITE) && wb_ready));
    end

    // Higher lanes sit later in the chain, so they win on overlapping bits.
    assign chain[0] = vbuf;
    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        vec_wb_lane_merge #(.VLEN(VLEN), .LANE_WIDTH(LANE_WIDTH)) u_merge (
            .buf_in  (chain[g]),
            .data    (vd_a[g]),
            .offset  (regi_a[g]),
            .w       (chunk_w),
            .enable  (lane_en[g]),
            .buf_out (chain[g+1]),
            .drop    (lane_drop[g])
        );
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state   <= ST_IDLE;
            vbuf    <= '0;
            wb_vreg <= '0;
            err     <= 1'b0;
        end else if (accept_start) begin
            state   <= ST_COLLECT;
            vbuf    <= old_vd;
            wb_vreg <= vd_addr;
            err     <= stray;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (stray) err <= 1'b1;
                end
                ST_COLLECT: begin
                    vbuf <= chain[NUM_LANES];
                    if (|lane_drop) err <= 1'b1;
                    if (beat_last) state <= ST_WRITE;
                end
                ST_WRITE: begin
                    if (stray) err <= 1'b1;
                    if (wb_ready) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign busy      = (state != ST_IDLE);
    assign wb_valid  = (state == ST_WRITE);
    assign wb_data   = vbuf;
    assign state_dbg = state;

endmodule
